// File: rtl/parity_stream.sv
`default_nettype none
// ============================================================================
// Module   : parity_stream
// Function : Serial LSB-first parity generator / checker, one frame of WIDTH
//            bits at a time. Optional error counter under PARITY_STREAM_ERRCNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module parity_stream #(
    parameter int WIDTH = 8,
    parameter int ODD   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode,
    input  logic       din,
    input  logic       din_valid,
    input  logic       abort,
    output logic       busy,
    output logic       par_out,
    output logic       par_valid,
    output logic       err
`ifdef PARITY_STREAM_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam int                 c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic               c_odd   = (ODD != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_PAR  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_mode;
    logic               r_acc;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_err_pend;
    logic               r_busy;
    logic               r_par_out;
    logic               r_par_valid;
    logic               r_err;
`ifdef PARITY_STREAM_ERRCNT_EN
    logic [7:0]         r_err_cnt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mode      <= 1'b0;
            r_acc       <= 1'b0;
            r_cnt       <= '0;
            r_err_pend  <= 1'b0;
            r_busy      <= 1'b0;
            r_par_out   <= 1'b0;
            r_par_valid <= 1'b0;
            r_err       <= 1'b0;
`ifdef PARITY_STREAM_ERRCNT_EN
            r_err_cnt   <= 8'd0;
`endif
        end else begin
            r_par_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode     <= mode;
                        r_acc      <= 1'b0;
                        r_cnt      <= '0;
                        r_err_pend <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    // abort wins over a bit arriving in the same cycle
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (din_valid) begin
                        r_acc <= r_acc ^ din;
                        r_cnt <= r_cnt + c_cnt_w'(1);
                        if (r_cnt == c_last) begin
                            r_state <= r_mode ? S_PAR : S_DONE;
                        end
                    end
                end
                S_PAR: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (din_valid) begin
                        r_err_pend <= din ^ (r_acc ^ c_odd);
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_par_out   <= r_acc ^ c_odd;
                    r_err       <= r_err_pend;
                    r_par_valid <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
`ifdef PARITY_STREAM_ERRCNT_EN
                    if (r_err_pend && (r_err_cnt != 8'hFF)) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
`endif
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign par_out   = r_par_out;
    assign par_valid = r_par_valid;
    assign err       = r_err;
`ifdef PARITY_STREAM_ERRCNT_EN
    assign err_cnt   = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_parity_stream.sv
`default_nettype none
// Bench for parity_stream: three instances (8/even, 8/odd, 4/odd) share stimulus;
// only the selected instance is started, and results are scoreboarded on par_valid.
module tb_parity_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode;
    logic       din;
    logic       din_valid;
    logic       abort;
    logic [2:0] start_v;
    logic [2:0] busy_v;
    logic [2:0] po_v;
    logic [2:0] pv_v;
    logic [2:0] err_v;
    logic [1:0] sel;
`ifdef PARITY_STREAM_ERRCNT_EN
    logic [7:0] ec_v [3];
`endif

    always #5 clk = ~clk;

    parity_stream #(.WIDTH(8), .ODD(0)) u_e8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .mode(mode), .din(din),
        .din_valid(din_valid), .abort(abort), .busy(busy_v[0]), .par_out(po_v[0]),
        .par_valid(pv_v[0]), .err(err_v[0])
`ifdef PARITY_STREAM_ERRCNT_EN
        , .err_cnt(ec_v[0])
`endif
    );

    parity_stream #(.WIDTH(8), .ODD(1)) u_o8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .mode(mode), .din(din),
        .din_valid(din_valid), .abort(abort), .busy(busy_v[1]), .par_out(po_v[1]),
        .par_valid(pv_v[1]), .err(err_v[1])
`ifdef PARITY_STREAM_ERRCNT_EN
        , .err_cnt(ec_v[1])
`endif
    );

    parity_stream #(.WIDTH(4), .ODD(1)) u_o4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .mode(mode), .din(din),
        .din_valid(din_valid), .abort(abort), .busy(busy_v[2]), .par_out(po_v[2]),
        .par_valid(pv_v[2]), .err(err_v[2])
`ifdef PARITY_STREAM_ERRCNT_EN
        , .err_cnt(ec_v[2])
`endif
    );

    typedef struct {
        logic [1:0] sel;
        logic       md;
        int         nbits;
        logic [7:0] data;
        logic       pbit;
        logic       ep;
        logic       ee;
    } vec_t;

    typedef struct {
        logic p;
        logic e;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // Scoreboard consumer: every par_valid of the selected instance pops one result.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if ((pv_v & ~(3'b001 << sel)) != 3'b000) begin
                n_checks++;
                n_fail++;
                $display("FAIL stray_pv: par_valid vector %b, selected %0d", pv_v, sel);
            end
            if (pv_v[sel]) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pv: par_valid on inst %0d, required none", sel);
                end else begin
                    mon_e = q.pop_front();
                    check("par_out", {7'd0, po_v[sel]}, {7'd0, mon_e.p});
                    check("err", {7'd0, err_v[sel]}, {7'd0, mon_e.e});
                end
            end
        end
    end

    task automatic drain(input logic [1:0] s);
        for (int k = 0; k < 6 && q.size() != 0; k++) tick();
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d results outstanding, required 0", q.size());
            q.delete();
        end
        check("busy_end", {7'd0, busy_v[s]}, 8'd0);
    endtask

    task automatic latency(input logic [1:0] s);
        check("pv_early", {7'd0, pv_v[s]}, 8'd0);
        tick();
        check("pv_latency", {7'd0, pv_v[s]}, 8'd1);
        drain(s);
    endtask

    // Start is issued with din_valid=1 (must not be consumed) and mode is
    // flipped right after the start cycle (must not matter).
    task automatic run_frame(input logic [1:0] s, input logic md, input int nbits,
                             input logic [7:0] data, input logic pbit,
                             input logic ep, input logic ee);
        exp_t e;
        e.p = ep;
        e.e = ee;
        sel       = s;
        start_v   = 3'b001 << s;
        mode      = md;
        din       = 1'b1;
        din_valid = 1'b1;
        tick();
        start_v   = 3'b000;
        mode      = ~md;
        din_valid = 1'b0;
        check("busy_start", {7'd0, busy_v[s]}, 8'd1);
        for (int i = 0; i < nbits; i++) begin
            din       = data[i];
            din_valid = 1'b1;
            if (i == nbits - 1 && !md) q.push_back(e);
            tick();
        end
        if (md) begin
            din       = pbit;
            din_valid = 1'b1;
            q.push_back(e);
            tick();
        end
        din_valid = 1'b0;
        latency(s);
    endtask

    vec_t vt [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] gv;
        logic [6:0] gd;
        exp_t       e;

        vt[0] = '{2'd0, 1'b0, 8, 8'h0D, 1'b0, 1'b1, 1'b0};
        vt[1] = '{2'd0, 1'b0, 8, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[2] = '{2'd0, 1'b1, 8, 8'hA5, 1'b0, 1'b0, 1'b0};
        vt[3] = '{2'd1, 1'b1, 8, 8'hFF, 1'b1, 1'b1, 1'b0};
        vt[4] = '{2'd1, 1'b1, 8, 8'hFF, 1'b0, 1'b1, 1'b1};
        vt[5] = '{2'd1, 1'b0, 8, 8'h07, 1'b0, 1'b0, 1'b0};
        vt[6] = '{2'd2, 1'b0, 4, 8'h0F, 1'b0, 1'b1, 1'b0};
        vt[7] = '{2'd2, 1'b1, 4, 8'h01, 1'b0, 1'b0, 1'b0};
        vt[8] = '{2'd0, 1'b1, 8, 8'h01, 1'b0, 1'b1, 1'b1};

        sel       = 2'd0;
        rst_n     = 1'b0;
        start_v   = 3'b000;
        mode      = 1'b0;
        din       = 1'b0;
        din_valid = 1'b0;
        abort     = 1'b0;
        tick();
        tick();
        check("rst_busy", {5'd0, busy_v}, 8'd0);
        check("rst_par_out", {5'd0, po_v}, 8'd0);
        check("rst_par_valid", {5'd0, pv_v}, 8'd0);
        check("rst_err", {5'd0, err_v}, 8'd0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 9; v++) begin
            run_frame(vt[v].sel, vt[v].md, vt[v].nbits, vt[v].data,
                      vt[v].pbit, vt[v].ep, vt[v].ee);
        end
`ifdef PARITY_STREAM_ERRCNT_EN
        check("err_cnt_o8", ec_v[1], 8'd1);
        check("err_cnt_e8", ec_v[0], 8'd1);
`endif

        // Gapped din_valid on the 4-bit instance, with a stray start/mode mid-frame.
        gv  = 7'b1011001;
        gd  = 7'b0111111;
        sel = 2'd2;
        start_v = 3'b100;
        mode    = 1'b0;
        tick();
        start_v = 3'b000;
        e.p = 1'b0;
        e.e = 1'b0;
        for (int i = 0; i < 7; i++) begin
            din       = gd[i];
            din_valid = gv[i];
            start_v   = (i == 2) ? 3'b100 : 3'b000;
            mode      = (i == 2);
            if (i == 6) q.push_back(e);
            tick();
            if (i < 6) check("gap_busy", {7'd0, busy_v[2]}, 8'd1);
        end
        start_v   = 3'b000;
        din_valid = 1'b0;
        latency(2'd2);

        // Abort with a simultaneous bit after 3 bits; prior par_out=1, err=1.
        sel     = 2'd0;
        start_v = 3'b001;
        mode    = 1'b0;
        tick();
        start_v = 3'b000;
        for (int i = 0; i < 3; i++) begin
            din       = 1'b1;
            din_valid = 1'b1;
            tick();
        end
        abort = 1'b1;
        tick();
        abort     = 1'b0;
        din_valid = 1'b0;
        check("abort_busy", {7'd0, busy_v[0]}, 8'd0);
        repeat (4) tick();
        check("abort_par_out", {7'd0, po_v[0]}, 8'd1);
        check("abort_err", {7'd0, err_v[0]}, 8'd1);
        run_frame(2'd0, 1'b1, 8, 8'h01, 1'b0, 1'b1, 1'b1);

        // Reset mid-DATA, then a clean all-zero generate frame.
        start_v = 3'b001;
        mode    = 1'b0;
        tick();
        start_v = 3'b000;
        for (int i = 0; i < 3; i++) begin
            din       = 1'b1;
            din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
        rst_n     = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_busy", {7'd0, busy_v[0]}, 8'd0);
        check("mid_rst_par_out", {7'd0, po_v[0]}, 8'd0);
        check("mid_rst_err", {7'd0, err_v[0]}, 8'd0);
        run_frame(2'd0, 1'b0, 8, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();

`ifdef PARITY_STREAM_ERRCNT_EN
        check("err_cnt_after_rst", ec_v[1], 8'd0);
        for (int f = 0; f < 260; f++) begin
            run_frame(2'd1, 1'b1, 8, 8'hFF, 1'b0, 1'b1, 1'b1);
        end
        check("err_cnt_sat", ec_v[1], 8'd255);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/parity_stream.md
PARITY_STREAM -- requirements
Module: parity_stream

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data bits per frame (legal 2..64).
REQ-002 The block SHALL have parameter ODD, default 0, selecting the parity sense: 0 = even, 1 = odd.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, the reset; it is synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit, a frame-start request, sampled only in IDLE.
REQ-006 The block SHALL have port mode, input, 1 bit, sampled with start: 0 = generate, 1 = check.
REQ-007 The block SHALL have port din, input, 1 bit, the serial data bit, LSB first.
REQ-008 The block SHALL have port din_valid, input, 1 bit, marking din as valid this cycle.
REQ-009 The block SHALL have port abort, input, 1 bit, a frame-abort request.
REQ-010 The block SHALL have port busy, output, 1 bit, high in any state other than IDLE.
REQ-011 The block SHALL have port par_out, output, 1 bit, the computed parity bit.
REQ-012 The block SHALL have port par_valid, output, 1 bit, a one-cycle frame-complete pulse.
REQ-013 The block SHALL have port err, output, 1 bit, the check-mode mismatch flag.

Function
REQ-014 The block SHALL implement states IDLE, DATA, PAR and DONE, with all outputs registered.
- IDLE: start=1 latches mode, clears the accumulator and bit counter, and moves to DATA next edge.
- IDLE: din_valid is ignored.
REQ-015 In DATA, each cycle with din_valid=1 SHALL XOR din into the accumulator and increment the bit counter.
- The counter is $clog2(WIDTH) bits wide.
- Cycles with din_valid=0 hold all state; there is no timeout.
REQ-016 When bit WIDTH-1 is accepted in DATA, the next state SHALL be DONE if mode=0, or PAR if mode=1.
REQ-017 In PAR, the first din_valid=1 cycle SHALL capture din as the received parity bit and move to DONE.
- err_next = din XOR (acc XOR ODD).
REQ-018 On entry to DONE, the block SHALL set par_out = acc XOR ODD and set err.
- err = err_next in check mode; err = 0 in generate mode.
- par_valid = 1 for exactly one cycle.
- Next state is IDLE unconditionally.
REQ-019 Latency: par_valid SHALL rise on the clock edge after the edge that accepted the final bit (data bit in generate mode, parity bit in check mode).
REQ-020 par_out and err SHALL hold their values from DONE until the next DONE, or until reset.
REQ-021 start asserted in DATA, PAR or DONE SHALL be ignored and SHALL NOT restart the frame.
REQ-022 abort=1 in DATA or PAR SHALL return the block to IDLE on the next edge.
- No par_valid is produced; par_out and err are unchanged.
- abort takes priority over din_valid in the same cycle.
- abort has no effect in IDLE or DONE.
REQ-023 start in IDLE and a simultaneous din_valid SHALL NOT consume din; the first data bit is taken in DATA.
REQ-024 mode changes after the start cycle SHALL have no effect on the current frame.

Reset
REQ-025 While rst_n=0 at a clock edge, the block SHALL enter IDLE and clear the following to 0: accumulator, bit counter, busy, par_out, par_valid and err.
REQ-026 Reset applied mid-frame SHALL discard the frame, and the first start after reset is released SHALL be honoured.

Configuration
REQ-027 With macro PARITY_STREAM_ERRCNT_EN defined, the block SHALL add output port err_cnt, 8 bits.
- err_cnt increments in each DONE cycle where err becomes 1.
- err_cnt saturates at 255.
- err_cnt is cleared only by reset.
REQ-028 Without PARITY_STREAM_ERRCNT_EN, the err_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-029 The bench SHALL cover: WIDTH=8, ODD=0, mode=0, bits 1,0,1,1,0,0,0,0 -> par_valid pulses one cycle after the 8th bit; par_out=1; err=0.
REQ-030 The bench SHALL cover: WIDTH=8, ODD=1, mode=1, data 0xFF followed by parity bit 1 -> par_out=1, err=0; then the same data with parity bit 0 -> err=1 (err_cnt=1 when the macro is defined).
REQ-031 The bench SHALL cover: WIDTH=4, din_valid gapped as 1,0,0,1,1,0,1 with bits 1,x,x,1,1,x,0 -> exactly 4 bits accepted; par_out=0.
REQ-032 The bench SHALL cover: abort=1 together with din_valid=1 after 3 bits -> busy=0 next cycle; no par_valid; par_out and err keep their prior values.
REQ-033 The bench SHALL cover: rst_n=0 for one edge mid-DATA, then start with mode=0 and 8 zero bits -> par_out=0; par_valid pulses once.
REQ-034 The bench SHALL cover: with the macro defined, 260 consecutive check frames carrying bad parity -> err_cnt reads 255.
